// File: rtl/scard_activation_seq.sv
// scard_activation_seq: smart card power-up, clock start, RST release and ATR watch, plus timed deactivation
module scard_activation_seq #(
  parameter int VCC_DLY   = 64,
  parameter int RST_DLY   = 512,
  parameter int ATR_TMO   = 40000,
  parameter int DEACT_DLY = 8,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_present,
  input  logic       act_req,
  input  logic       deact_req,
  input  logic       card_io_in,
  output logic       card_power_en,
  output logic       card_clk_en,
  output logic       card_rst_n,
  output logic       card_io_hold,
  output logic       active,
  output logic       atr_seen,
  output logic       timeout_err,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PWR_UP   = 3'd1,
    CLK_ON   = 3'd2,
    ATR_WAIT = 3'd3,
    ACTIVE   = 3'd4,
    DEACT    = 3'd5
  } state_t;
  localparam logic [CNT_W-1:0] L_VCC  = CNT_W'(VCC_DLY - 1);
  localparam logic [CNT_W-1:0] L_RST  = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] L_ATR  = CNT_W'(ATR_TMO - 1);
  localparam logic [CNT_W-1:0] L_D1   = CNT_W'(DEACT_DLY);
  localparam logic [CNT_W-1:0] L_D2   = CNT_W'(2 * DEACT_DLY);
  localparam logic [CNT_W-1:0] L_D3   = CNT_W'(3 * DEACT_DLY);
  localparam logic [CNT_W-1:0] L_DEND = CNT_W'(4 * DEACT_DLY - 1);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sync;
  logic             r_tmo;
  logic             w_abort, w_fall, w_start, w_tmo_hit, w_deact;
  // r_sync[1] is the synchronized I/O level, r_sync[2] its value one cycle earlier
  assign w_fall    = r_sync[2] & ~r_sync[1];
  assign w_abort   = deact_req | ~card_present;
  assign w_start   = (r_state == IDLE) & act_req & card_present;
  assign w_tmo_hit = (r_state == ATR_WAIT) & ~w_abort & ~w_fall & (r_cnt == L_ATR);
  assign w_deact   = (r_state == DEACT);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = w_start ? PWR_UP : IDLE;
      PWR_UP:   w_next = w_abort ? DEACT : (r_cnt == L_VCC) ? CLK_ON : PWR_UP;
      CLK_ON:   w_next = w_abort ? DEACT : (r_cnt == L_RST) ? ATR_WAIT : CLK_ON;
      ATR_WAIT: w_next = w_abort ? DEACT : w_fall ? ACTIVE : (r_cnt == L_ATR) ? DEACT : ATR_WAIT;
      ACTIVE:   w_next = w_abort ? DEACT : ACTIVE;
      DEACT:    w_next = (r_cnt == L_DEND) ? IDLE : DEACT;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sync  <= 3'b111;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      r_sync  <= {r_sync[1:0], card_io_in};
      r_tmo   <= w_tmo_hit ? 1'b1 : w_start ? 1'b0 : r_tmo;
    end
  end
  assign card_power_en = (r_state inside {PWR_UP, CLK_ON, ATR_WAIT, ACTIVE}) | (w_deact & (r_cnt < L_D3));
  assign card_clk_en   = (r_state inside {CLK_ON, ATR_WAIT, ACTIVE}) | (w_deact & (r_cnt < L_D1));
  assign card_rst_n    = (r_state inside {ATR_WAIT, ACTIVE});
  assign card_io_hold  = (r_state == IDLE) | (w_deact & (r_cnt >= L_D2));
  assign active        = (r_state == ACTIVE);
  assign atr_seen      = (r_state == ACTIVE) & (r_cnt == '0);
  assign timeout_err   = r_tmo;
  assign state         = r_state;
endmodule

// File: tb/tb_scard_activation_seq.sv
// tb_scard_activation_seq: directed checks of activation, ATR timeout, deactivation, removal and reset
module tb_scard_activation_seq;
  logic       clk = 0, rst = 1;
  logic       card_present = 0, act_req = 0, deact_req = 0, card_io_in = 1;
  logic       card_power_en, card_clk_en, card_rst_n, card_io_hold, active, atr_seen, timeout_err;
  logic [2:0] state;
  int         n_chk = 0, n_pass = 0;

  scard_activation_seq #(.VCC_DLY(4), .RST_DLY(10), .ATR_TMO(50), .DEACT_DLY(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .card_present(card_present), .act_req(act_req), .deact_req(deact_req),
    .card_io_in(card_io_in), .card_power_en(card_power_en), .card_clk_en(card_clk_en),
    .card_rst_n(card_rst_n), .card_io_hold(card_io_hold), .active(active), .atr_seen(atr_seen),
    .timeout_err(timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_state", state, 0);
    chk("rst_power", card_power_en, 0);
    chk("rst_clk", card_clk_en, 0);
    chk("rst_rstn", card_rst_n, 0);
    chk("rst_hold", card_io_hold, 1);
    chk("rst_active", active, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_atr", atr_seen, 0);
    tick(2);
    rst = 0;
    tick();
    // nominal activation, act_req driven just after edge N
    card_present = 1; act_req = 1;
    tick(); act_req = 0;
    chk("nom_n1_state", state, 1);
    chk("nom_n1_power", card_power_en, 1);
    chk("nom_n1_clk", card_clk_en, 0);
    chk("nom_n1_hold", card_io_hold, 0);
    tick(3);
    chk("nom_n4_clk", card_clk_en, 0);
    tick();
    chk("nom_n5_clk", card_clk_en, 1);
    chk("nom_n5_state", state, 2);
    tick(9);
    chk("nom_n14_rstn", card_rst_n, 0);
    tick();
    chk("nom_n15_rstn", card_rst_n, 1);
    chk("nom_n15_state", state, 3);
    tick(5);
    card_io_in = 0;
    tick(2);
    chk("nom_n22_state", state, 3);
    tick();
    chk("nom_n23_state", state, 4);
    chk("nom_n23_active", active, 1);
    chk("nom_n23_atr", atr_seen, 1);
    tick();
    chk("nom_n24_atr", atr_seen, 0);
    chk("nom_n24_active", active, 1);
    // deactivation from ACTIVE, with act_req held during DEACT
    deact_req = 1; card_io_in = 1;
    tick(); deact_req = 0; act_req = 1;
    chk("dea_1_state", state, 5);
    chk("dea_1_rstn", card_rst_n, 0);
    chk("dea_1_clk", card_clk_en, 1);
    chk("dea_1_active", active, 0);
    tick();
    chk("dea_2_clk", card_clk_en, 1);
    tick();
    chk("dea_3_clk", card_clk_en, 0);
    chk("dea_3_hold", card_io_hold, 0);
    tick();
    chk("dea_4_hold", card_io_hold, 0);
    tick();
    chk("dea_5_hold", card_io_hold, 1);
    chk("dea_5_power", card_power_en, 1);
    tick();
    chk("dea_6_power", card_power_en, 1);
    tick();
    chk("dea_7_power", card_power_en, 0);
    tick();
    chk("dea_8_state", state, 5);
    act_req = 0;
    tick();
    chk("dea_9_state", state, 0);
    tick();
    chk("dea_10_state", state, 0);
    // ATR timeout with I/O held high
    act_req = 1;
    tick(); act_req = 0;
    tick(14);
    chk("tmo_n15_state", state, 3);
    tick(49);
    chk("tmo_n64_state", state, 3);
    chk("tmo_n64_flag", timeout_err, 0);
    tick();
    chk("tmo_n65_state", state, 5);
    chk("tmo_n65_flag", timeout_err, 1);
    tick(7);
    chk("tmo_n72_state", state, 5);
    tick();
    chk("tmo_n73_state", state, 0);
    chk("tmo_sticky", timeout_err, 1);
    // new activation clears the flag, then card removal in CLK_ON
    act_req = 1;
    tick(); act_req = 0;
    chk("rem_state1", state, 1);
    chk("rem_tmo_clr", timeout_err, 0);
    tick(4);
    chk("rem_clkon", state, 2);
    card_present = 0;
    tick();
    chk("rem_deact", state, 5);
    tick(7);
    chk("rem_deact_end", state, 5);
    tick();
    chk("rem_idle", state, 0);
    act_req = 1;
    tick(3);
    chk("rem_absent_state", state, 0);
    chk("rem_absent_power", card_power_en, 0);
    act_req = 0;
    // I/O edge lands in the timeout cycle
    card_present = 1; act_req = 1;
    tick(); act_req = 0;
    tick(61);
    card_io_in = 0;
    tick(2);
    chk("coin_n64_state", state, 3);
    tick();
    chk("coin_n65_state", state, 4);
    chk("coin_n65_tmo", timeout_err, 0);
    chk("coin_n65_atr", atr_seen, 1);
    deact_req = 1; card_io_in = 1;
    tick(); deact_req = 0;
    tick(8);
    chk("coin_idle", state, 0);
    // act_req with deact_req in IDLE activates; then async reset mid ATR_WAIT
    act_req = 1; deact_req = 1;
    tick(); act_req = 0; deact_req = 0;
    chk("both_state", state, 1);
    tick(15);
    chk("arst_pre_state", state, 3);
    chk("arst_pre_power", card_power_en, 1);
    rst = 1;
    #2;
    chk("arst_state", state, 0);
    chk("arst_power", card_power_en, 0);
    chk("arst_clk", card_clk_en, 0);
    chk("arst_hold", card_io_hold, 1);
    tick(2);
    rst = 0;
    tick(3);
    chk("arst_after", state, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
